// File: rtl/draw_scheduler.sv
// draw_scheduler: once per frame tick, grants the shared VGA plot port to each
// requesting client (erase, bricks, paddle, ball) in fixed order, then pulses UPDATE.
module draw_scheduler #(
    parameter int FRAME_DIV = 833333,
    parameter int TIMEOUT   = 4096
) (
    input  logic        CLOCK_50,
    input  logic        RESETN,
    input  logic [3:0]  REQ,
    input  logic [3:0]  DONE,
    input  logic [31:0] X_IN,
    input  logic [31:0] Y_IN,
    input  logic [11:0] COLOUR_IN,
    input  logic [3:0]  PLOT_IN,
    output logic [3:0]  GRANT,
    output logic [3:0]  START,
    output logic [7:0]  XOUT,
    output logic [7:0]  YOUT,
    output logic [2:0]  COLOUR,
    output logic        PLOT,
    output logic        UPDATE,
    output logic        BUSY,
    output logic [3:0]  ERR,
    output logic        OVERRUN
);
    localparam int CW = $clog2(FRAME_DIV);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_START, S_RUN, S_UPDATE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wd, w_wd_nxt;
    logic [3:0]    r_mask, w_mask_nxt, r_err, w_err_nxt, w_onehot, w_cidx;
    logic [1:0]    r_cur, w_cur_nxt;
    logic [7:0]    r_x, w_x_nxt, r_y, w_y_nxt;
    logic [2:0]    r_c, w_c_nxt;
    logic          r_plot, w_plot_nxt, r_ovr, w_tick, w_done, w_expired;

    assign w_tick    = r_cnt == CW'(FRAME_DIV - 1);
    assign w_onehot  = 4'b0001 << r_cur;
    assign w_cidx    = {2'b00, r_cur} + {1'b0, r_cur, 1'b0};
    assign w_done    = DONE[r_cur];
    assign w_expired = r_wd == WW'(TIMEOUT - 1);

    assign GRANT   = (r_state == S_START || r_state == S_RUN) ? w_onehot : 4'b0000;
    assign START   = (r_state == S_START) ? w_onehot : 4'b0000;
    assign UPDATE  = r_state == S_UPDATE;
    assign BUSY    = r_state != S_IDLE;
    assign XOUT    = r_x;
    assign YOUT    = r_y;
    assign COLOUR  = r_c;
    assign PLOT    = r_plot;
    assign ERR     = r_err;
    assign OVERRUN = r_ovr;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_cur_nxt   = r_cur;
        w_wd_nxt    = r_wd;
        w_err_nxt   = r_err;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_c_nxt     = r_c;
        w_plot_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_mask_nxt  = REQ;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_state_nxt = (r_mask == 4'b0000) ? S_UPDATE : S_START;
                for (int i = 3; i >= 0; i--)
                    if (r_mask[i]) w_cur_nxt = 2'(i);
            end
            S_START: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_x_nxt    = X_IN[{r_cur, 3'b000} +: 8];
                w_y_nxt    = Y_IN[{r_cur, 3'b000} +: 8];
                w_c_nxt    = COLOUR_IN[w_cidx +: 3];
                w_plot_nxt = PLOT_IN[r_cur];
                // DONE takes priority over a watchdog expiry in the same cycle
                if (w_done || w_expired) begin
                    w_mask_nxt  = r_mask & ~w_onehot;
                    w_err_nxt   = w_done ? r_err : (r_err | w_onehot);
                    w_state_nxt = S_SELECT;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_cur   <= '0;
            r_wd    <= '0;
            r_err   <= '0;
            r_ovr   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_c     <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_mask  <= w_mask_nxt;
            r_cur   <= w_cur_nxt;
            r_wd    <= w_wd_nxt;
            r_err   <= w_err_nxt;
            r_ovr   <= r_ovr | (w_tick && r_state != S_IDLE);
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_c     <= w_c_nxt;
            r_plot  <= w_plot_nxt;
        end
    end
endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-rate scheduler that shares the single VGA-adapter plot port among four pixel-drawing clients: erase, bricks, paddle, ball. Once per frame tick it services each requesting client in fixed order, forwarding that client's X/Y/colour/plot stream to the adapter. After the last client finishes, it pulses an update strobe to the game logic, e.g. the brick module's update input.

## Interface
- FRAME_DIV, default 833333: cycles per frame tick (60 Hz at 50 MHz); must be ≥ 2
- TIMEOUT, default 4096: maximum cycles a client may hold the grant; must be ≥ 2
- CLOCK_50  in  1  system clock; all logic on its rising edge
- RESETN  in  1  synchronous, active-low reset
- REQ  in  4  client i has drawing work this frame; index 0 = erase, 1 = bricks, 2 = paddle, 3 = ball
- DONE  in  4  client i has finished its stream (level, sampled in RUN only)
- X_IN  in  32  client i X coordinate in bits [8i+7:8i]
- Y_IN  in  32  client i Y coordinate in bits [8i+7:8i]
- COLOUR_IN  in  12  client i colour in bits [3i+2:3i]
- PLOT_IN  in  4  client i pixel valid
- GRANT  out  4  one-hot; high for the served client in START and RUN
- START  out  4  one-cycle pulse to the granted client on entering service
- XOUT, YOUT  out  8  registered to adapter
- COLOUR  out  3  registered to adapter
- PLOT  out  1  registered to adapter
- UPDATE  out  1  one-cycle pulse at end of each serviced frame
- BUSY  out  1  high whenever the state is not IDLE
- ERR  out  4  sticky; bit i set when client i timed out
- OVERRUN  out  1  sticky; a frame tick arrived while not IDLE

## Operation
- Frame counter: FRAME_DIV-wide counter running 0..FRAME_DIV-1 and wrapping. TICK is combinational, asserted when the count equals FRAME_DIV-1.
- State IDLE: on TICK, latch mask ← REQ and go to SELECT.
- State SELECT: if the mask is zero, go to UPDATE. Otherwise latch cur ← lowest set bit index and go to START.
- State START (1 cycle): GRANT[cur]=1 and START[cur]=1. Clear the watchdog. Go to RUN.
- State RUN: GRANT[cur]=1.
  - Forward client cur: next XOUT/YOUT/COLOUR ← its fields; next PLOT ← PLOT_IN[cur].
  - On DONE[cur]: clear mask[cur] and go to SELECT.
  - Otherwise, if watchdog = TIMEOUT-1: set ERR[cur], clear mask[cur], go to SELECT.
  - Otherwise increment the watchdog.
- State UPDATE (1 cycle): UPDATE=1. Go to IDLE.
- Outside RUN, PLOT is registered as 0. XOUT, YOUT and COLOUR hold their last values.
- DONE, PLOT_IN and REQ from non-granted clients are ignored. REQ changes after the tick latch do not affect the current frame.
- Simultaneous events:
  - DONE[cur] in the same cycle as a PLOT_IN[cur] pixel: the pixel is still forwarded.
  - DONE[cur] in the same cycle the watchdog expires: DONE wins and ERR is not set.
- TICK while not IDLE: the tick is dropped, OVERRUN is set, and the current frame continues.
- Reset (any state): state → IDLE, frame counter 0, mask 0, cur 0, watchdog 0. All outputs are 0, including ERR and OVERRUN.

## Timing
- Tick at cycle T (count = FRAME_DIV-1): SELECT at T+1, START pulse at T+2, RUN from T+3.
- Empty mask: UPDATE at T+2, IDLE at T+3.
- Pixel latency: PLOT_IN[cur]/X/Y/COLOUR at RUN cycle k appear on PLOT/XOUT/YOUT/COLOUR at k+1.
- DONE seen at RUN cycle D: GRANT falls at D+1 (SELECT). The next client's START is at D+2. If no client remains, UPDATE is at D+2.
- Per-client overhead: 3 cycles (SELECT, START, and the DONE cycle).
- Watchdog: with no DONE, the abort happens in the RUN cycle at which the watchdog equals TIMEOUT-1, i.e. the TIMEOUT-th RUN cycle.
- The first tick after reset release occurs FRAME_DIV-1 cycles after the first non-reset cycle.

## Test plan
- FRAME_DIV=100, TIMEOUT=16, REQ=0000 → UPDATE pulses 2 cycles after each tick; GRANT, START and PLOT stay 0; BUSY is high for 2 cycles.
- REQ=1111; each client plots 3 pixels at X=10i, Y=i, colour=i+1, then raises DONE → START order 0,1,2,3; adapter receives 12 pixels in order, each 1 cycle late; UPDATE follows 2 cycles after client 3's DONE.
- REQ=0100; client 2 never asserts DONE → GRANT=0100 for 16 RUN cycles; ERR=0100; UPDATE follows; ERR persists across later frames until RESETN=0.
- Client 1 holds DONE high during START and RUN; the non-granted client 3 raises PLOT and DONE → DONE is ignored in START; client 1 ends after its first RUN cycle; no client-3 pixel reaches PLOT.
- FRAME_DIV=20; client 0 takes 30 cycles → OVERRUN=1, the second tick is dropped, the frame completes with exactly one UPDATE.
- RESETN low for 1 cycle mid-RUN of client 2 → next cycle all outputs and the frame counter read 0 and state is IDLE; the next tick starts from client 0 with a fresh mask.
